// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter bit                SKID   = 1'b1,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic              acc;
  logic              take;

  assign acc       = in_valid & in_ready;
  assign take      = m_v & out_ready;
  assign out_valid = m_v;
  assign out_data  = m_d;

  if (SKID) begin : g_skid
    logic              s_v;
    logic [DATA_W-1:0] s_d;

    // Ready depends only on skid occupancy, so it never sees out_ready.
    assign in_ready = ~s_v;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
      // NOTE: payload registers are reset on purpose: they must hold the safe
      // BUBBLE encoding, not X, whenever the stage is empty.
      if (rst || flush) begin
        m_v <= 1'b0;
        m_d <= BUBBLE;
        s_v <= 1'b0;
        s_d <= BUBBLE;
      end else if (!m_v || take) begin
        if (s_v) begin
          m_v <= 1'b1;
          m_d <= s_d;
          s_v <= acc;
          if (acc) s_d <= in_data;
        end else begin
          m_v <= acc;
          if (acc) m_d <= in_data;
        end
      end else if (acc) begin
        s_v <= 1'b1;
        s_d <= in_data;
      end
    end
  end else begin : g_single
    assign in_ready = out_ready | ~m_v;

    // On take without acc the payload is left in place; only valid drops.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        m_v <= 1'b0;
        m_d <= BUBBLE;
      end else if (acc) begin
        m_v <= 1'b1;
        m_d <= in_data;
      end else if (take) begin
        m_v <= 1'b0;
      end
    end
  end

  // Flush deliberately leaves the counter alone; only rst and cnt_clr zero it.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (m_v && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (bubble 0x13, 4-bit counter)
// checked through a payload scoreboard, plus a single-register instance.
module tb_pipe_stage_reg;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
  logic [W-1:0] a_in_data, a_out_data;
  logic [3:0]   a_stall_cnt;
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
  logic [W-1:0] b_in_data, b_out_data;
  logic [15:0]  b_stall_cnt;

  pipe_stage_reg #(.DATA_W(W), .BUBBLE(32'h0000_0013), .SKID(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .cnt_clr(a_cnt_clr), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(W), .BUBBLE(32'h0), .SKID(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop happens mid-cycle, where the coming edge's take is visible.
  task automatic tick();
    @(negedge clk);
    if (a_out_valid && a_out_ready && !a_flush && !rst) begin
      if (exp_q.size() == 0) check("a_unexpected_out", a_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("a_out_data", a_out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [W-1:0] d, input logic rdy);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_cnt_clr = 1'b0;
    b_flush = 1'b0; b_cnt_clr = 1'b0;
    drive_a(1'b1, 32'hDEAD_BEEF, 1'b0);
    b_in_valid = 1'b1; b_in_data = 32'hDEAD_BEEF; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_a(1'b0, '0, 1'b0);
    b_in_valid = 1'b0;

    // Reset state
    check("a_rst_valid", a_out_valid, 0);
    check("a_rst_data", a_out_data, 32'h13);
    check("a_rst_cnt", a_stall_cnt, 0);
    check("a_rst_ready", a_in_ready, 1);
    check("b_rst_valid", b_out_valid, 0);
    check("b_rst_data", b_out_data, 0);
    check("b_rst_cnt", b_stall_cnt, 0);
    check("b_rst_ready", b_in_ready, 1);

    // Streaming: 1,2,3 back to back, downstream always ready
    for (int i = 1; i <= 3; i++) begin
      drive_a(1'b1, W'(i), 1'b1);
      exp_q.push_back(W'(i));
      check("stream_ready", a_in_ready, 1);
      tick();
      check("stream_valid", a_out_valid, 1);
    end
    drive_a(1'b0, '0, 1'b1);
    tick();
    check("stream_drained", a_out_valid, 0);
    check("stream_q_empty", exp_q.size(), 0);
    check("stream_cnt", a_stall_cnt, 0);

    // Backpressure: B lands in skid, C waits upstream
    drive_a(1'b1, 32'hA, 1'b1); exp_q.push_back(32'hA);
    check("bp_ready_a", a_in_ready, 1);
    tick();
    drive_a(1'b1, 32'hB, 1'b0); exp_q.push_back(32'hB);
    check("bp_ready_b", a_in_ready, 1);
    tick();
    drive_a(1'b1, 32'hC, 1'b0); exp_q.push_back(32'hC);
    check("bp_ready_full", a_in_ready, 0);
    tick();
    check("bp_ready_hold", a_in_ready, 0);
    tick();
    check("bp_stable_valid", a_out_valid, 1);
    check("bp_stable_data", a_out_data, 32'hA);
    a_out_ready = 1'b1;
    check("bp_ready_release", a_in_ready, 0);
    tick();
    check("bp_ready_reopen", a_in_ready, 1);
    tick();
    drive_a(1'b0, '0, 1'b1);
    tick();
    tick();
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_stall_cnt", a_stall_cnt, 3);

    // Flush with both entries full and a new item offered
    drive_a(1'b1, 32'h5, 1'b0);
    tick();
    drive_a(1'b1, 32'h6, 1'b0);
    tick();
    drive_a(1'b1, 32'h7, 1'b0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    drive_a(1'b0, '0, 1'b0);
    check("flush_valid", a_out_valid, 0);
    check("flush_data", a_out_data, 32'h13);
    check("flush_ready", a_in_ready, 1);
    drive_a(1'b1, 32'h8, 1'b1); exp_q.push_back(32'h8);
    tick();
    drive_a(1'b0, '0, 1'b1);
    tick();
    check("flush_q_empty", exp_q.size(), 0);

    // Saturating stall counter (4 bits)
    a_cnt_clr = 1'b1;
    tick();
    a_cnt_clr = 1'b0;
    check("cnt_clr_idle", a_stall_cnt, 0);
    drive_a(1'b1, 32'h9, 1'b0); exp_q.push_back(32'h9);
    tick();
    drive_a(1'b0, '0, 1'b0);
    repeat (20) tick();
    check("cnt_saturate", a_stall_cnt, 15);
    check("cnt_hold_data", a_out_data, 32'h9);
    a_cnt_clr = 1'b1;
    tick();
    a_cnt_clr = 1'b0;
    check("cnt_clr_pulse", a_stall_cnt, 0);
    tick();
    check("cnt_restart", a_stall_cnt, 1);
    a_cnt_clr = 1'b1;
    tick();
    a_cnt_clr = 1'b0;
    check("cnt_clr_wins", a_stall_cnt, 0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("cnt_q_empty", exp_q.size(), 0);

    // Single-register mode: combinational pass-through on a full stage
    b_in_valid = 1'b1; b_in_data = 32'h10; b_out_ready = 1'b0;
    tick();
    check("b_full_valid", b_out_valid, 1);
    b_in_data = 32'h11;
    #1;
    check("b_ready_blocked", b_in_ready, 0);
    b_out_ready = 1'b1;
    #1;
    check("b_ready_pass", b_in_ready, 1);
    tick();
    check("b_pass_valid", b_out_valid, 1);
    check("b_pass_data", b_out_data, 32'h11);
    b_in_valid = 1'b0;
    tick();
    check("b_take_valid", b_out_valid, 0);
    check("b_take_data_held", b_out_data, 32'h11);
    check("b_stall_cnt", b_stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
